// File: rtl/pause_sequencer_pkg.sv
// Shared types for the uP pause network: sequencer state encoding and cause bit layout.
package uproc_pkg;

    typedef enum logic [2:0] {
        RUN     = 3'd0,
        DRAIN   = 3'd1,
        PAUSED  = 3'd2,
        STEP    = 3'd3,
        RELEASE = 3'd4
    } sm_pause_t;

    localparam int unsigned CAUSE_MAP  = 0;
    localparam int unsigned CAUSE_JTAG = 1;
    localparam int unsigned CAUSE_PIN  = 2;

    function automatic logic [2:0] make_cause(input logic pin, input logic jtag, input logic map);
        logic [2:0] c;
        c             = '0;
        c[CAUSE_PIN]  = pin;
        c[CAUSE_JTAG] = jtag;
        c[CAUSE_MAP]  = map;
        return c;
    endfunction

    function automatic logic start_of(input sm_pause_t s);
        return (s == DRAIN) || (s == PAUSED);
    endfunction

endpackage

// File: rtl/pause_sequencer_if.sv
// Pause request/acknowledge bundle between the requesters/core and the pause sequencer.
interface pause_sequencer_if;

    logic       i_pinPause;
    logic       i_jtagPause;
    logic       i_mapPause;
    logic       i_jtagStep;
    logic       i_isBooted;
    logic       i_coreNowPaused;
    logic       i_clrTimeout;
    logic       o_smStartPause;
    logic       o_smIsPaused;
    logic [2:0] o_pauseCause;
    logic       o_drainTimeout;

    modport slave (
        input  i_pinPause, i_jtagPause, i_mapPause, i_jtagStep,
               i_isBooted, i_coreNowPaused, i_clrTimeout,
        output o_smStartPause, o_smIsPaused, o_pauseCause, o_drainTimeout
    );

    modport master (
        output i_pinPause, i_jtagPause, i_mapPause, i_jtagStep,
               i_isBooted, i_coreNowPaused, i_clrTimeout,
        input  o_smStartPause, o_smIsPaused, o_pauseCause, o_drainTimeout
    );

endinterface

// File: rtl/pause_sequencer_timeout_ctr.sv
// Saturating drain-cycle counter; o_expired flags the last allowed DRAIN cycle.
module pause_timeout_ctr #(
    parameter int unsigned TIMEOUT_CYC = 1024,
    parameter int unsigned CNT_W       = 11
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam logic [CNT_W-1:0] LAST = (TIMEOUT_CYC == 0) ? '0 : CNT_W'(TIMEOUT_CYC - 1);
    localparam logic             ENABLED = (TIMEOUT_CYC != 0);

    logic [CNT_W-1:0] r_cnt;

    // Stops at LAST rather than wrapping; held at zero when the timeout is disabled.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr || !ENABLED) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != LAST)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expired = ENABLED && (r_cnt == LAST);

endmodule

// File: rtl/pause_sequencer.sv
// Pause sequencer: merges pause requests, handshakes with the core, adds drain timeout,
// cause capture and JTAG single-step. All outputs are registered from the next state.
module pause_sequencer
    import uproc_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 1024,
    parameter int unsigned CNT_W       = 11
) (
    input  logic              i_clk,
    input  logic              i_rst,
    pause_sequencer_if.slave  bus
);

    sm_pause_t  r_state;
    logic       r_start;
    logic       r_isPaused;
    logic [2:0] r_cause;
    logic       r_drainTimeout;

    sm_pause_t  w_next;
    logic       w_req;
    logic       w_expired;
    logic       w_setTimeout;
    logic [2:0] w_causeIn;

    assign w_req     = bus.i_pinPause | bus.i_jtagPause | bus.i_mapPause;
    assign w_causeIn = make_cause(bus.i_pinPause, bus.i_jtagPause, bus.i_mapPause);

    // Counter is cleared in every non-DRAIN state, so each DRAIN entry starts at zero.
    pause_timeout_ctr #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .CNT_W       (CNT_W)
    ) u_timeout_ctr (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_clr     (r_state != DRAIN),
        .i_en      (r_state == DRAIN),
        .o_expired (w_expired)
    );

    always_comb begin
        w_next = r_state;
        if (!bus.i_isBooted) begin
            w_next = RUN;
        end else begin
            unique case (r_state)
                RUN:     if (w_req) w_next = DRAIN;
                DRAIN: begin
                    if (bus.i_coreNowPaused) w_next = PAUSED;
                    else if (!w_req)         w_next = RELEASE;
                    else if (w_expired)      w_next = RELEASE;
                end
                PAUSED: begin
                    if (!w_req)              w_next = RELEASE;
                    else if (bus.i_jtagStep) w_next = STEP;
                end
                STEP:    w_next = w_req ? DRAIN : RELEASE;
                RELEASE: if (!bus.i_coreNowPaused) w_next = RUN;
                default: w_next = RUN;
            endcase
        end
    end

    assign w_setTimeout = bus.i_isBooted && (r_state == DRAIN) && !bus.i_coreNowPaused
                          && w_req && w_expired;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= RUN;
            r_start        <= 1'b0;
            r_isPaused     <= 1'b0;
            r_cause        <= '0;
            r_drainTimeout <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_start    <= start_of(w_next);
            r_isPaused <= (w_next == PAUSED);
            if (!bus.i_isBooted) begin
                r_cause <= '0;
            end else if ((r_state == RUN) && (w_next == DRAIN)) begin
                r_cause <= w_causeIn;
            end
            if (w_setTimeout) begin
                r_drainTimeout <= 1'b1;
            end else if (bus.i_clrTimeout) begin
                r_drainTimeout <= 1'b0;
            end
        end
    end

    assign bus.o_smStartPause = r_start;
    assign bus.o_smIsPaused   = r_isPaused;
    assign bus.o_pauseCause   = r_cause;
    assign bus.o_drainTimeout = r_drainTimeout;

endmodule
